// File: rtl/branch_resolver.sv
// Branch resolver: queues predicted branches from fetch, resolves them against EX,
// drives the predictor update bus, and issues flush/redirect on a mispredict.
module branch_resolver #(
  parameter int ADDRESS_WIDTH = 22,
  parameter int GHR_SIZE      = 8,
  parameter int DEPTH         = 4,
  parameter int FLUSH_CYCLES  = 2,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset_n,
  input  logic                     i_IF_valid,
  input  logic                     i_IF_taken,
  input  logic [ADDRESS_WIDTH-1:0] i_IF_pc,
  input  logic [ADDRESS_WIDTH-1:0] i_IF_target,
  input  logic                     i_EX_valid,
  input  logic                     i_EX_taken,
  input  logic [ADDRESS_WIDTH-1:0] i_EX_target,
  output logic                     o_full,
  output logic                     o_ALU_outcome,
  output logic [GHR_SIZE-1:0]      o_ALU_pc,
  output logic                     o_ALU_isbranch,
  output logic                     o_ALU_prediction,
  output logic                     o_flush,
  output logic                     o_redirect_valid,
  output logic [ADDRESS_WIDTH-1:0] o_redirect_pc,
  output logic [CNT_WIDTH-1:0]     o_branch_count,
  output logic [CNT_WIDTH-1:0]     o_mispredict_count,
  output logic                     o_underflow
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t                   state;
  logic [FCW-1:0]           flush_cnt;
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [CW-1:0]            count;
  logic [ADDRESS_WIDTH-1:0] pc_mem  [DEPTH];
  logic [ADDRESS_WIDTH-1:0] tgt_mem [DEPTH];
  logic [DEPTH-1:0]         pred_mem;

  logic                     run;
  logic                     empty;
  logic                     pop;
  logic                     push;
  logic                     do_push;
  logic                     mispredict;
  logic                     flush_now;
  logic [ADDRESS_WIDTH-1:0] head_pc;
  logic [ADDRESS_WIDTH-1:0] head_tgt;
  logic                     head_pred;

  assign run       = (state == RUN);
  assign empty     = (count == '0);
  assign o_full    = (count == CW'(DEPTH));
  assign head_pc   = pc_mem[rd_ptr];
  assign head_tgt  = tgt_mem[rd_ptr];
  assign head_pred = pred_mem[rd_ptr];

  assign pop        = i_EX_valid & run & ~empty;
  assign push       = i_IF_valid & run & (~o_full | pop);
  assign mispredict = (head_pred != i_EX_taken) |
                      (head_pred & i_EX_taken & (head_tgt != i_EX_target));
  assign flush_now  = pop & mispredict;
  // A push alongside a mispredicted pop is younger than the branch, hence wrong path.
  assign do_push    = push & ~flush_now;

  always_ff @(posedge i_Clk) begin
    if (do_push) begin
      pc_mem[wr_ptr]   <= i_IF_pc;
      tgt_mem[wr_ptr]  <= i_IF_target;
      pred_mem[wr_ptr] <= i_IF_taken;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      state              <= RUN;
      flush_cnt          <= '0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      o_ALU_outcome      <= 1'b0;
      o_ALU_pc           <= '0;
      o_ALU_isbranch     <= 1'b0;
      o_ALU_prediction   <= 1'b0;
      o_flush            <= 1'b0;
      o_redirect_valid   <= 1'b0;
      o_redirect_pc      <= '0;
      o_branch_count     <= '0;
      o_mispredict_count <= '0;
      o_underflow        <= 1'b0;
    end else begin
      o_ALU_isbranch   <= pop;
      o_redirect_valid <= 1'b0;

      if (i_EX_valid && run && empty) o_underflow <= 1'b1;

      if (pop) begin
        o_ALU_outcome    <= i_EX_taken;
        o_ALU_pc         <= head_pc[GHR_SIZE-1:0];
        o_ALU_prediction <= head_pred;
        if (o_branch_count != '1) o_branch_count <= o_branch_count + 1'b1;
        if (mispredict && (o_mispredict_count != '1))
          o_mispredict_count <= o_mispredict_count + 1'b1;
      end

      case (state)
        RUN: begin
          if (flush_now) begin
            state            <= FLUSH;
            flush_cnt        <= FCW'(FLUSH_CYCLES - 1);
            o_flush          <= 1'b1;
            o_redirect_valid <= 1'b1;
            o_redirect_pc    <= i_EX_taken ? i_EX_target : head_pc + ADDRESS_WIDTH'(1);
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
          end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
              2'b10:   count <= count + 1'b1;
              2'b01:   count <= count - 1'b1;
              default: count <= count;
            endcase
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            state   <= RUN;
            o_flush <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed scenarios plus random traffic, checked against
// a reference FIFO/flush model through a scoreboard of expected update-bus words.
module tb_branch_resolver;

  localparam int AW    = 22;
  localparam int GW    = 8;
  localparam int DEPTH = 4;
  localparam int FC    = 2;
  localparam int CW    = 16;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic          pred;
    logic [AW-1:0] tgt;
  } ent_t;

  logic          i_Clk = 1'b0;
  logic          i_Reset_n = 1'b0;
  logic          i_IF_valid = 1'b0, i_IF_taken = 1'b0;
  logic [AW-1:0] i_IF_pc = '0, i_IF_target = '0;
  logic          i_EX_valid = 1'b0, i_EX_taken = 1'b0;
  logic [AW-1:0] i_EX_target = '0;
  logic          o_full, o_ALU_outcome, o_ALU_isbranch, o_ALU_prediction;
  logic [GW-1:0] o_ALU_pc;
  logic          o_flush, o_redirect_valid, o_underflow;
  logic [AW-1:0] o_redirect_pc;
  logic [CW-1:0] o_branch_count, o_mispredict_count;

  branch_resolver #(.ADDRESS_WIDTH(AW), .GHR_SIZE(GW), .DEPTH(DEPTH),
                    .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
    .i_Clk(i_Clk), .i_Reset_n(i_Reset_n),
    .i_IF_valid(i_IF_valid), .i_IF_taken(i_IF_taken), .i_IF_pc(i_IF_pc),
    .i_IF_target(i_IF_target), .i_EX_valid(i_EX_valid), .i_EX_taken(i_EX_taken),
    .i_EX_target(i_EX_target), .o_full(o_full), .o_ALU_outcome(o_ALU_outcome),
    .o_ALU_pc(o_ALU_pc), .o_ALU_isbranch(o_ALU_isbranch),
    .o_ALU_prediction(o_ALU_prediction), .o_flush(o_flush),
    .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
    .o_branch_count(o_branch_count), .o_mispredict_count(o_mispredict_count),
    .o_underflow(o_underflow)
  );

  always #5 i_Clk = ~i_Clk;

  int n_cmp = 0;
  int n_err = 0;

  ent_t          mq[$];
  logic [9:0]    exp_q[$];
  logic [AW-1:0] redir_q[$];
  logic [9:0]    last_alu;
  int            flush_left;
  int            m_bc, m_mc;
  logic          m_uf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    redir_q.delete();
    last_alu   = '0;
    flush_left = 0;
    m_bc       = 0;
    m_mc       = 0;
    m_uf       = 1'b0;
  endtask

  task automatic do_reset();
    i_Reset_n  = 1'b0;
    i_IF_valid = 1'b0;
    i_EX_valid = 1'b0;
    tick();
    model_clear();
    check("rst_flush", o_flush, 0);
    check("rst_full", o_full, 0);
    check("rst_isbranch", o_ALU_isbranch, 0);
    check("rst_alu_bus", {o_ALU_outcome, o_ALU_pc, o_ALU_prediction}, 0);
    check("rst_redirect_valid", o_redirect_valid, 0);
    check("rst_redirect_pc", o_redirect_pc, 0);
    check("rst_branch_count", o_branch_count, 0);
    check("rst_mispredict_count", o_mispredict_count, 0);
    check("rst_underflow", o_underflow, 0);
    i_Reset_n = 1'b1;
  endtask

  // One clock: drive inputs, advance the model, then compare all outputs.
  task automatic cycle(input logic if_v, input logic if_t, input logic [AW-1:0] if_pc,
                       input logic [AW-1:0] if_tgt, input logic ex_v, input logic ex_t,
                       input logic [AW-1:0] ex_tgt);
    logic exp_isb, exp_rv, pop, push, misp;
    ent_t h;
    i_IF_valid = if_v; i_IF_taken = if_t; i_IF_pc = if_pc; i_IF_target = if_tgt;
    i_EX_valid = ex_v; i_EX_taken = ex_t; i_EX_target = ex_tgt;
    exp_isb = 1'b0;
    exp_rv  = 1'b0;
    if (flush_left == 0) begin
      pop  = ex_v && (mq.size() > 0);
      push = if_v && ((mq.size() < DEPTH) || pop);
      if (ex_v && mq.size() == 0) m_uf = 1'b1;
      misp = 1'b0;
      if (pop) begin
        h = mq[0];
        misp = (h.pred != ex_t) || (h.pred && ex_t && (h.tgt != ex_tgt));
        exp_q.push_back({ex_t, h.pc[GW-1:0], h.pred});
        exp_isb = 1'b1;
        if (m_bc < 16'hFFFF) m_bc++;
        if (misp && m_mc < 16'hFFFF) m_mc++;
      end
      if (misp) begin
        mq.delete();
        redir_q.push_back(ex_t ? ex_tgt : h.pc + AW'(1));
        exp_rv     = 1'b1;
        flush_left = FC;
      end else begin
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back('{pc: if_pc, pred: if_t, tgt: if_tgt});
      end
    end else begin
      flush_left--;
    end
    tick();
    check("full", o_full, mq.size() == DEPTH);
    check("flush", o_flush, flush_left > 0);
    check("isbranch", o_ALU_isbranch, exp_isb);
    if (o_ALU_isbranch && exp_q.size() > 0) last_alu = exp_q.pop_front();
    check("alu_bus", {o_ALU_outcome, o_ALU_pc, o_ALU_prediction}, last_alu);
    check("redirect_valid", o_redirect_valid, exp_rv);
    if (o_redirect_valid && redir_q.size() > 0) check("redirect_pc", o_redirect_pc, redir_q.pop_front());
    check("branch_count", o_branch_count, m_bc);
    check("mispredict_count", o_mispredict_count, m_mc);
    check("underflow", o_underflow, m_uf);
  endtask

  task automatic idle();
    cycle(0, 0, '0, '0, 0, 0, '0);
  endtask

  task automatic push_br(input logic pred, input logic [AW-1:0] pc, input logic [AW-1:0] tgt);
    cycle(1, pred, pc, tgt, 0, 0, '0);
  endtask

  task automatic resolve(input logic taken, input logic [AW-1:0] tgt);
    cycle(0, 0, '0, '0, 1, taken, tgt);
  endtask

  logic [AW-1:0] tsel[4];

  initial begin
    tsel[0] = 22'h40; tsel[1] = 22'h44; tsel[2] = 22'h80; tsel[3] = 22'h1234;
    model_clear();
    do_reset();

    // T1: correct taken prediction
    push_br(1, 22'h10, 22'h40);
    resolve(1, 22'h40);
    check("t1_branch_count", o_branch_count, 1);

    // T2: predicted not-taken, actually taken
    push_br(0, 22'h20, 22'h0);
    resolve(1, 22'h80);
    check("t2_redirect_pc", o_redirect_pc, 22'h80);
    idle(); idle(); idle();

    // T3: target mismatch, then taken-predicted but not taken; EX/IF during flush ignored
    push_br(1, 22'h28, 22'h40);
    resolve(1, 22'h44);
    idle(); idle();
    push_br(1, 22'h30, 22'h50);
    resolve(0, 22'h0);
    check("t3_redirect_pc", o_redirect_pc, 22'h31);
    cycle(1, 1, 22'h99, 22'h9, 1, 1, 22'h9);
    cycle(1, 1, 22'h98, 22'h9, 1, 1, 22'h9);
    idle();

    // T4: fill, dropped push while full, push+pop while full, drain across wrap
    for (int i = 0; i < DEPTH; i++) push_br(1'($urandom_range(0, 1)), 22'h100 + AW'(i), 22'h200 + AW'(i));
    push_br(1, 22'h104, 22'h204);
    cycle(1, 0, 22'h105, 22'h0, 1, mq[0].pred, mq[0].tgt);
    for (int i = 0; i < DEPTH; i++) resolve(mq[0].pred, mq[0].tgt);

    // T5: EX with empty FIFO
    resolve(1, 22'h40);
    idle();

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 22'h3FFFFF)),
            tsel[$urandom_range(0, 3)], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            tsel[$urandom_range(0, 3)]);

    // T6: reset in the middle of a flush
    idle(); idle(); idle();
    push_br(0, 22'h60, 22'h0);
    resolve(1, 22'h70);
    do_reset();
    idle();

    // T6: saturation of the branch counter under continuous push+pop
    push_br(0, 22'h0, 22'h0);
    for (int i = 1; i <= 65540; i++) cycle(1, 0, AW'(i), 22'h0, 1, 0, 22'h0);
    check("sat_branch_count", o_branch_count, 16'hFFFF);
    resolve(1, 22'h77);
    check("sat_after_misp", o_branch_count, 16'hFFFF);
    idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
